// File: rtl/qspi_byte_engine.sv
// Register-mapped SPI mode-0 byte engine with single-bit and quad lanes.
// Every accepted request yields one response: read data, write ack, or end of a bus transfer.
module qspi_byte_engine (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       qspi_if_req_vld,
    output logic       qspi_if_req_rdy,
    input  logic [3:0] qspi_if_req_addr,
    input  logic       qspi_if_req_read,
    input  logic [7:0] qspi_if_req_dat,
    output logic       qspi_if_rsp_vld,
    input  logic       qspi_if_rsp_rdy,
    output logic [7:0] qspi_if_rsp_dat,
    output logic       qspi_if_switch_qspi,
    output logic       qspi_if_sck,
    output logic       qspi_if_csn,
    output logic       qspi_if_dq0_en,
    output logic       qspi_if_dq0_o,
    input  logic       qspi_if_dq0_i,
    output logic       qspi_if_dq1_en,
    output logic       qspi_if_dq1_o,
    input  logic       qspi_if_dq1_i,
    output logic       qspi_if_dq2_en,
    output logic       qspi_if_dq2_o,
    input  logic       qspi_if_dq2_i,
    output logic       qspi_if_dq3_en,
    output logic       qspi_if_dq3_o,
    input  logic       qspi_if_dq3_i
);

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_CSN    = 4'h1;
    localparam logic [3:0] ADDR_TXDATA = 4'h2;
    localparam logic [3:0] ADDR_RXDATA = 4'h3;
    localparam logic [3:0] ADDR_STAT   = 4'h4;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        RSP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic       csn_q, csn_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] samp_q, samp_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] rem_q, rem_d;
    logic [7:0] rsp_dat_q, rsp_dat_d;

    logic       quad;
    logic       qdir;
    logic [3:0] div;
    logic [3:0] pins_in;
    logic       active;

    assign quad    = ctrl_q[1];
    assign qdir    = ctrl_q[2];
    assign div     = ctrl_q[7:4];
    assign pins_in = {qspi_if_dq3_i, qspi_if_dq2_i, qspi_if_dq1_i, qspi_if_dq0_i};
    assign active  = (state_q == LO) || (state_q == HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ctrl_q     <= 8'h00;
            csn_q      <= 1'b1;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            rx_valid_q <= 1'b0;
            shift_q    <= 8'h00;
            samp_q     <= 8'h00;
            cnt_q      <= 4'h0;
            rem_q      <= 3'h0;
            rsp_dat_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            csn_q      <= csn_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_valid_q <= rx_valid_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            rsp_dat_q  <= rsp_dat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        csn_d      = csn_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_valid_d = rx_valid_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        rsp_dat_d  = rsp_dat_q;

        case (state_q)
            IDLE: begin
                if (qspi_if_req_vld) begin
                    if (!qspi_if_req_read && (qspi_if_req_addr == ADDR_TXDATA)) begin
                        tx_d    = qspi_if_req_dat;
                        shift_d = qspi_if_req_dat;
                        samp_d  = 8'h00;
                        cnt_d   = 4'h0;
                        rem_d   = quad ? 3'd1 : 3'd7;
                        state_d = LO;
                    end else begin
                        state_d   = RSP;
                        rsp_dat_d = 8'h00;
                        if (qspi_if_req_read) begin
                            case (qspi_if_req_addr)
                                ADDR_CTRL:   rsp_dat_d = ctrl_q;
                                ADDR_CSN:    rsp_dat_d = {7'h00, csn_q};
                                ADDR_TXDATA: rsp_dat_d = tx_q;
                                ADDR_RXDATA: begin
                                    rsp_dat_d  = rx_q;
                                    rx_valid_d = 1'b0;
                                end
                                ADDR_STAT:   rsp_dat_d = {7'h00, rx_valid_q};
                                default:     rsp_dat_d = 8'h00;
                            endcase
                        end else begin
                            case (qspi_if_req_addr)
                                ADDR_CTRL: ctrl_d = qspi_if_req_dat & 8'hF7;
                                ADDR_CSN:  csn_d  = qspi_if_req_dat[0];
                                default:   ;
                            endcase
                        end
                    end
                end
            end
            // Input lanes are captured on the LO->HI transition, i.e. the SCK rising edge.
            LO: begin
                if (cnt_q == div) begin
                    cnt_d   = 4'h0;
                    state_d = HI;
                    samp_d  = quad ? {samp_q[3:0], pins_in} : {samp_q[6:0], qspi_if_dq1_i};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (cnt_q == div) begin
                    cnt_d = 4'h0;
                    if (rem_q != 3'd0) begin
                        rem_d   = rem_q - 3'd1;
                        shift_d = quad ? {shift_q[3:0], 4'h0} : {shift_q[6:0], 1'b0};
                        state_d = LO;
                    end else begin
                        rx_d       = samp_q;
                        rx_valid_d = 1'b1;
                        rsp_dat_d  = 8'h00;
                        state_d    = RSP;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RSP: begin
                if (qspi_if_rsp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign qspi_if_req_rdy     = (state_q == IDLE);
    assign qspi_if_rsp_vld     = (state_q == RSP);
    assign qspi_if_rsp_dat     = rsp_dat_q;
    assign qspi_if_switch_qspi = ctrl_q[0];
    assign qspi_if_sck         = (state_q == HI);
    assign qspi_if_csn         = csn_q;

    // Single mode keeps WP#/HOLD# driven high at all times; quad mode hands all lanes to qdir.
    always_comb begin
        qspi_if_dq0_en = 1'b1;
        qspi_if_dq1_en = 1'b0;
        qspi_if_dq2_en = 1'b1;
        qspi_if_dq3_en = 1'b1;
        qspi_if_dq0_o  = 1'b0;
        qspi_if_dq1_o  = 1'b0;
        qspi_if_dq2_o  = 1'b1;
        qspi_if_dq3_o  = 1'b1;
        if (quad) begin
            qspi_if_dq0_en = ~qdir;
            qspi_if_dq1_en = ~qdir;
            qspi_if_dq2_en = ~qdir;
            qspi_if_dq3_en = ~qdir;
            {qspi_if_dq3_o, qspi_if_dq2_o, qspi_if_dq1_o, qspi_if_dq0_o} =
                active ? shift_q[7:4] : 4'h0;
        end else begin
            qspi_if_dq0_o = active & shift_q[7];
        end
    end

endmodule

// File: tb/tb_qspi_byte_engine.sv
// Randomized self-checking bench for qspi_byte_engine against a register/byte level model.
// Pins are driven per SCK period from a table and lane outputs are captured at each SCK rise.
module tb_qspi_byte_engine;

    logic       clk;
    logic       rst_n;
    logic       req_vld;
    logic       req_rdy;
    logic [3:0] req_addr;
    logic       req_read;
    logic [7:0] req_dat;
    logic       rsp_vld;
    logic       rsp_rdy;
    logic [7:0] rsp_dat;
    logic       switch_qspi;
    logic       sck;
    logic       csn;
    logic       dq0_en, dq0_o, dq0_i;
    logic       dq1_en, dq1_o, dq1_i;
    logic       dq2_en, dq2_o, dq2_i;
    logic       dq3_en, dq3_o, dq3_i;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_ctrl;
    logic [7:0] m_tx;
    logic [7:0] m_rx;
    logic       m_csn;
    logic       m_rxv;
    logic       m_rx_known;

    logic [3:0] pin_vals [0:7];
    int         fall_cnt = 0;
    int         pin_base = 0;
    logic [3:0] pins_drv;
    logic [7:0] edge_q [$];

    qspi_byte_engine dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .qspi_if_req_vld     (req_vld),
        .qspi_if_req_rdy     (req_rdy),
        .qspi_if_req_addr    (req_addr),
        .qspi_if_req_read    (req_read),
        .qspi_if_req_dat     (req_dat),
        .qspi_if_rsp_vld     (rsp_vld),
        .qspi_if_rsp_rdy     (rsp_rdy),
        .qspi_if_rsp_dat     (rsp_dat),
        .qspi_if_switch_qspi (switch_qspi),
        .qspi_if_sck         (sck),
        .qspi_if_csn         (csn),
        .qspi_if_dq0_en      (dq0_en),
        .qspi_if_dq0_o       (dq0_o),
        .qspi_if_dq0_i       (dq0_i),
        .qspi_if_dq1_en      (dq1_en),
        .qspi_if_dq1_o       (dq1_o),
        .qspi_if_dq1_i       (dq1_i),
        .qspi_if_dq2_en      (dq2_en),
        .qspi_if_dq2_o       (dq2_o),
        .qspi_if_dq2_i       (dq2_i),
        .qspi_if_dq3_en      (dq3_en),
        .qspi_if_dq3_o       (dq3_o),
        .qspi_if_dq3_i       (dq3_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Each SCK period presents the next table entry; the entry changes when SCK falls.
    always @(negedge sck) fall_cnt = fall_cnt + 1;

    always_comb begin
        int k;
        k = fall_cnt - pin_base;
        pins_drv = 4'h0;
        if (k >= 0 && k < 8) pins_drv = pin_vals[k[2:0]];
    end

    assign {dq3_i, dq2_i, dq1_i, dq0_i} = pins_drv;

    always @(posedge sck) edge_q.push_back({dq3_en, dq2_en, dq1_en, dq0_en, dq3_o, dq2_o, dq1_o, dq0_o});

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_ctrl     = 8'h00;
        m_csn      = 1'b1;
        m_tx       = 8'h00;
        m_rx       = 8'h00;
        m_rxv      = 1'b0;
        m_rx_known = 1'b1;
    endtask

    function automatic logic [7:0] modelRead(input logic [3:0] a);
        case (a)
            4'h0:    return m_ctrl;
            4'h1:    return {7'h00, m_csn};
            4'h2:    return m_tx;
            4'h3:    return m_rx;
            4'h4:    return {7'h00, m_rxv};
            default: return 8'h00;
        endcase
    endfunction

    task automatic sendReq(input logic [3:0] a, input logic rd, input logic [7:0] d);
        int waitc;
        waitc = 0;
        @(negedge clk);
        req_addr = a;
        req_read = rd;
        req_dat  = d;
        req_vld  = 1'b1;
        while (!req_rdy && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_rdy) checkOutput("req_rdy_timeout", 32'(req_rdy), 32'd1);
        @(posedge clk);
        #1 req_vld = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic rd, input logic [7:0] d, input int hold,
                                 output logic [7:0] rdata, output int lat, output int hi_cyc);
        int bad;
        sendReq(a, rd, d);
        lat    = 0;
        hi_cyc = 0;
        rdata  = 8'h00;
        do begin
            @(negedge clk);
            lat++;
            if (sck) hi_cyc++;
        end while (!rsp_vld && lat < 5000);
        if (!rsp_vld) begin
            checkOutput("rsp_timeout", 32'(rsp_vld), 32'd1);
            return;
        end
        rdata = rsp_dat;
        bad   = 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!rsp_vld || rsp_dat !== rdata || req_rdy) bad++;
        end
        if (hold > 0) checkOutput("backpressure_stable", bad, 0);
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1 rsp_rdy = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        logic [3:0] exp_en;
        logic [3:0] exp_o;
        if (m_ctrl[1]) begin
            exp_en = {4{~m_ctrl[2]}};
            exp_o  = 4'h0;
        end else begin
            exp_en = 4'b1101;
            exp_o  = 4'b1100;
        end
        checkOutput({tag, "_en"}, 32'({dq3_en, dq2_en, dq1_en, dq0_en}), 32'(exp_en));
        checkOutput({tag, "_o"}, 32'({dq3_o, dq2_o, dq1_o, dq0_o}), 32'(exp_o));
        checkOutput({tag, "_sck"}, 32'(sck), 32'd0);
    endtask

    task automatic doRead(input logic [3:0] a);
        logic [7:0] r;
        logic [7:0] exp;
        int lat, hi;
        exp = modelRead(a);
        applyStimulus(a, 1'b1, 8'h00, 0, r, lat, hi);
        checkOutput($sformatf("rd%0h_latency", a), lat, 1);
        if (a != 4'h3 || m_rx_known) checkOutput($sformatf("rd%0h_data", a), 32'(r), 32'(exp));
        if (a == 4'h3) m_rxv = 1'b0;
    endtask

    task automatic doWrite(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] r;
        int lat, hi;
        applyStimulus(a, 1'b0, d, 0, r, lat, hi);
        checkOutput($sformatf("wr%0h_latency", a), lat, 1);
        checkOutput($sformatf("wr%0h_ack", a), 32'(r), 32'd0);
        if (a == 4'h0) m_ctrl = d;
        if (a == 4'h1) m_csn = d[0];
        checkOutput("switch_qspi", 32'(switch_qspi), 32'(m_ctrl[0]));
        checkOutput("csn", 32'(csn), 32'(m_csn));
        checkIdle("idle");
    endtask

    task automatic doTransfer(input logic [7:0] tx, input logic [7:0] pat);
        int n, dv, lat, hi, rbase;
        logic quad, qdir;
        logic [7:0] r, e, t, p;
        logic [3:0] v, exp_o, exp_en;
        quad = m_ctrl[1];
        qdir = m_ctrl[2];
        dv   = int'(m_ctrl[7:4]);
        n    = quad ? 2 : 8;
        for (int i = 0; i < 8; i++) begin
            v = 4'($urandom);
            p = pat << i;
            if (quad) begin
                if (i == 0) v = pat[7:4];
                if (i == 1) v = pat[3:0];
            end else begin
                v[1] = p[7];
            end
            pin_vals[i] = v;
        end
        pin_base = fall_cnt;
        rbase    = edge_q.size();
        applyStimulus(4'h2, 1'b0, tx, 0, r, lat, hi);
        checkOutput("tx_bus_cycles", lat - 1, 2 * n * (dv + 1));
        checkOutput("tx_sck_high_cycles", hi, n * (dv + 1));
        checkOutput("tx_ack", 32'(r), 32'd0);
        checkOutput("tx_sck_edges", edge_q.size() - rbase, n);
        for (int i = 0; i < n && rbase + i < edge_q.size(); i++) begin
            e = edge_q[rbase + i];
            t = tx << (quad ? 4 * i : i);
            if (quad) begin
                exp_en = {4{~qdir}};
                exp_o  = t[7:4];
            end else begin
                exp_en = 4'b1101;
                exp_o  = {3'b110, t[7]};
            end
            checkOutput($sformatf("edge%0d_en", i), 32'(e[7:4]), 32'(exp_en));
            if (!(quad && qdir)) checkOutput($sformatf("edge%0d_o", i), 32'(e[3:0]), 32'(exp_o));
        end
        m_tx       = tx;
        m_rx       = pat;
        m_rxv      = 1'b1;
        m_rx_known = !quad || qdir;
        checkIdle("post_tx");
    endtask

    initial begin
        logic [7:0] r;
        int lat, hi, rbase, seen;
        logic [7:0] c, tx, pat;
        logic [3:0] a;
        int dv;
        logic quad, qdir;

        rst_n    = 1'b1;
        req_vld  = 1'b0;
        req_addr = 4'h0;
        req_read = 1'b0;
        req_dat  = 8'h00;
        rsp_rdy  = 1'b0;
        for (int i = 0; i < 8; i++) pin_vals[i] = 4'h0;
        modelReset();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_req_rdy", 32'(req_rdy), 32'd1);
        checkOutput("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        checkOutput("rst_rsp_dat", 32'(rsp_dat), 32'd0);
        checkOutput("rst_switch", 32'(switch_qspi), 32'd0);
        checkOutput("rst_csn", 32'(csn), 32'd1);
        checkIdle("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        doRead(4'h0);
        doRead(4'h1);
        doRead(4'h3);
        doRead(4'h4);
        doRead(4'h2);

        $display("[TB] single byte transfer");
        doWrite(4'h0, 8'h01);
        doWrite(4'h1, 8'h00);
        doTransfer(8'hA5, 8'h3C);
        doRead(4'h4);
        doRead(4'h3);
        doRead(4'h4);

        $display("[TB] quad write and quad read");
        doWrite(4'h0, 8'h13);
        doTransfer(8'h5A, 8'($urandom));
        doRead(4'h2);
        doWrite(4'h0, 8'h07);
        doTransfer(8'($urandom), 8'hC3);
        doRead(4'h3);

        $display("[TB] randomized transfers");
        for (int it = 0; it < 8; it++) begin
            dv   = $urandom_range(0, 3);
            if (it == 0) dv = 15;
            quad = 1'($urandom);
            qdir = quad ? 1'($urandom) : 1'b0;
            c    = {4'(dv), 1'b0, qdir, quad, 1'b1};
            tx   = 8'($urandom);
            pat  = 8'($urandom);
            doWrite(4'h0, c);
            doWrite(4'h1, 8'($urandom));
            doTransfer(tx, pat);
            doRead(4'h4);
            doRead(4'h3);
            doRead(4'h4);
            doRead(4'h2);
        end

        $display("[TB] back-pressure and unmapped addresses");
        applyStimulus(4'h1, 1'b1, 8'h00, 10, r, lat, hi);
        checkOutput("bp_latency", lat, 1);
        checkOutput("bp_data", 32'(r), 32'(modelRead(4'h1)));
        doWrite(4'h7, 8'($urandom));
        doRead(4'h7);
        a = 4'($urandom_range(5, 15));
        doWrite(a, 8'($urandom));
        doRead(a);
        doRead(4'h0);

        $display("[TB] reset in the middle of a transfer");
        doWrite(4'h0, 8'h11);
        doWrite(4'h1, 8'h00);
        rbase = edge_q.size();
        sendReq(4'h2, 1'b0, 8'h96);
        for (int k = 0; k < 500 && edge_q.size() - rbase < 5; k++) @(negedge clk);
        checkOutput("rst_reached_bit5", edge_q.size() - rbase, 5);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_sck", 32'(sck), 32'd0);
        checkOutput("midrst_csn", 32'(csn), 32'd1);
        checkOutput("midrst_switch", 32'(switch_qspi), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_vld) seen++;
        end
        checkOutput("midrst_no_rsp", seen, 0);
        checkOutput("midrst_req_rdy", 32'(req_rdy), 32'd1);
        doRead(4'h0);
        doRead(4'h1);
        doRead(4'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
